// File: rtl/uart_rx_fifo_feeder.sv
// uart_rx_fifo_feeder: oversampling 8N1 receiver feeding a FIFO through a one-entry holding register.
// Flags framing errors and overruns caused by FIFO back-pressure.
module uart_rx_fifo_feeder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       wr_clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       fifo_full,
    output logic       wr,
    output logic [7:0] data_out,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_bit, w_bit_nxt;
    logic [7:0]    r_shift, w_shift_nxt, r_hold;
    logic          r_pend, r_frame_err, r_overrun;
    logic          w_rx_s, w_tick, w_good, w_ferr, w_wr;

    assign w_rx_s    = r_sync[1];
    assign w_wr      = r_pend & ~fifo_full;
    assign wr        = w_wr;
    assign data_out  = r_hold;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = r_state != IDLE;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_good      = 1'b0;
        w_ferr      = 1'b0;
        w_tick      = (r_state == START) ? (r_cnt == HALF_M1) : (r_cnt == FULL_M1);
        case (r_state)
            IDLE: if (!w_rx_s) w_state_nxt = START;
            START: if (w_tick) begin
                w_state_nxt = w_rx_s ? IDLE : DATA;
                w_bit_nxt   = 3'd0;
            end
            DATA: if (w_tick) begin
                w_shift_nxt = {w_rx_s, r_shift[7:1]};
                w_bit_nxt   = r_bit + 3'd1;
                if (r_bit == 3'd7) w_state_nxt = STOP;
            end
            STOP: if (w_tick) begin
                w_good      = w_rx_s;
                w_ferr      = ~w_rx_s;
                w_state_nxt = w_rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: if (w_rx_s) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Counter only runs while timing a bit; every sample or state change restarts it.
        w_cnt_nxt = (w_state_nxt != r_state || w_tick || r_state == IDLE || r_state == WAIT_IDLE)
                    ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= 2'b11;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_hold      <= 8'h00;
            r_pend      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rx};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
            r_overrun   <= w_good & r_pend & ~w_wr;
            // A write in the same cycle frees the holding register for the new byte.
            if (w_good && (!r_pend || w_wr)) begin
                r_hold <= r_shift;
                r_pend <= 1'b1;
            end else if (w_wr) begin
                r_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo_feeder.sv
// tb_uart_rx_fifo_feeder: scoreboard bench for the serial receiver / FIFO feeder.
module tb_uart_rx_fifo_feeder;
    localparam int CPB = 16;

    logic       wr_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       fifo_full = 1'b0;
    logic       wr, frame_err, overrun, busy;
    logic [7:0] data_out;

    int n_chk = 0, n_bad = 0, n_wr = 0, n_ferr = 0, n_ovr = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo_feeder #(.CLKS_PER_BIT(CPB)) dut (
        .wr_clk(wr_clk), .reset_n(reset_n), .rx(rx), .fifo_full(fifo_full),
        .wr(wr), .data_out(data_out), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge wr_clk) begin
        if (wr) begin
            n_wr++;
            check("wr_while_full", 32'(fifo_full), 0);
            check("wr_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge wr_clk);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        idle(CPB);
    endtask

    // Leaves rx at the stop-bit level so a low stop can extend into a break.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    initial begin
        int w0;
        #1;
        check("rst_wr", 32'(wr), 0);
        check("rst_data", 32'(data_out), 0);
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        idle(3);
        reset_n = 1'b1;
        idle(4);

        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(CPB);
        check("a5_written", 32'(exp_q.size()), 0);
        check("a5_wr_count", 32'(n_wr), 1);
        check("a5_ferr", 32'(n_ferr), 0);
        check("a5_ovr", 32'(n_ovr), 0);

        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(CPB);
        check("b2b_wr_count", 32'(n_wr), 3);

        send_frame(8'h81, 1'b0);
        idle(3 * CPB);
        check("brk_ferr", 32'(n_ferr), 1);
        check("brk_busy", 32'(busy), 1);
        check("brk_no_wr", 32'(n_wr), 3);
        rx = 1'b1;
        idle(CPB);
        check("brk_idle", 32'(busy), 0);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(CPB);
        check("55_wr_count", 32'(n_wr), 4);
        check("55_ferr", 32'(n_ferr), 1);

        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * CPB);
        check("glitch_busy", 32'(busy), 0);
        check("glitch_wr", 32'(n_wr), 4);
        check("glitch_ferr", 32'(n_ferr), 1);

        fifo_full = 1'b1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        check("bp_ovr0", 32'(n_ovr), 0);
        send_frame(8'h22, 1'b1);
        idle(CPB);
        check("bp_ovr1", 32'(n_ovr), 1);
        check("bp_held", 32'(data_out), 32'h11);
        check("bp_no_wr", 32'(n_wr), 4);
        fifo_full = 1'b0;
        idle(CPB);
        check("bp_release_wr", 32'(n_wr), 5);
        check("bp_q_empty", 32'(exp_q.size()), 0);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rx = 1'b1;
        idle(CPB / 2);
        check("mid_busy", 32'(busy), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_data", 32'(data_out), 0);
        check("mrst_wr", 32'(wr), 0);
        check("mrst_ferr", 32'(frame_err), 0);
        check("mrst_ovr", 32'(overrun), 0);
        w0 = n_wr;
        idle(CPB);
        reset_n = 1'b1;
        idle(2 * CPB);
        check("mrst_no_wr", 32'(n_wr), 32'(w0));
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1);
        idle(CPB);
        check("0f_wr_count", 32'(n_wr), 6);
        check("final_q_empty", 32'(exp_q.size()), 0);
        check("final_ferr", 32'(n_ferr), 1);
        check("final_ovr", 32'(n_ovr), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
